wifi_tx_scheduler: RTL

Transmit scheduler that shares the single wifi transceiver transmit path among `NUM_REQ` requesters. It arbitrates round-robin, builds the framed 100-bit packet, issues a one-cycle start to the transceiver and waits for its busy pulse. It then waits for a link-level acknowledge and retries up to `MAX_RETRY` times on NACK or timeout. It sits between the MAC-side requesters and the transceiver's `data_in`/`tx_busy` interface.

---
 rtl/wifi_tx_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/wifi_tx_scheduler.sv
// Round-robin transmit scheduler: frames a requester's payload, starts the transceiver,
// then waits for busy and a link acknowledge, retrying on NACK or timeout.
module wifi_tx_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int ACK_TIMEOUT = 16,
   parameter int MAX_RETRY   = 3
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [32*NUM_REQ-1:0]        req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [NUM_REQ-1:0]           done,
   output logic [NUM_REQ-1:0]           fail,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         sched_busy,
   output logic                         tx_start,
   output logic [31:0]                  tx_data,
   output logic [99:0]                  tx_packet,
   input  logic                         tx_busy,
   input  logic                         ack_valid,
   input  logic                         ack_ok,
   output logic [2:0]                   retry_cnt
);

   localparam int IDW = $clog2(NUM_REQ);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_SEND      = 2'd1;
   localparam logic [1:0] S_WAIT_BUSY = 2'd2;
   localparam logic [1:0] S_WAIT_ACK  = 2'd3;

   localparam logic [7:0]         TO_LAST   = 8'(ACK_TIMEOUT - 1);
   localparam logic [2:0]         RETRY_MAX = 3'(MAX_RETRY);
   localparam logic [IDW:0]       NREQ_W    = (IDW+1)'(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

   logic [1:0]         state_q,  state_d;
   logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]     grant_q,  grant_d;
   logic [7:0]         cnt_q,    cnt_d;
   logic [2:0]         retry_q,  retry_d;
   logic [31:0]        data_q,   data_d;
   logic [99:0]        pkt_q,    pkt_d;
   logic [NUM_REQ-1:0] done_q,   done_d;
   logic [NUM_REQ-1:0] fail_q,   fail_d;

   logic [2*NUM_REQ-1:0] dbl_vld;
   logic [2*NUM_REQ-1:0] shifted_vld;
   logic [NUM_REQ-1:0]   rot_vld;
   logic [IDW:0]         off;
   logic [IDW:0]         sum;
   logic [IDW-1:0]       win_idx;
   logic                 win_found;
   logic [31:0]          win_dat;
   logic                 att_fail;

   // Rotate the request vector so bit 0 is the requester just after rr_ptr; lowest set bit wins.
   always_comb begin
      dbl_vld     = {req_valid, req_valid};
      shifted_vld = dbl_vld >> ({1'b0, rr_ptr_q} + (IDW+1)'(1));
      rot_vld     = shifted_vld[NUM_REQ-1:0];
      win_found   = |rot_vld;
      off         = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (rot_vld[j]) off = (IDW+1)'(j);
      end
      sum     = {1'b0, rr_ptr_q} + (IDW+1)'(1) + off;
      win_idx = (sum >= NREQ_W) ? IDW'(sum - NREQ_W) : IDW'(sum);
      win_dat = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (win_idx == IDW'(j)) win_dat = req_data[32*j +: 32];
      end
   end

   always_comb begin
      req_ready = '0;
      if (reset_n && state_q == S_IDLE && win_found) req_ready = ONE_HOT0 << win_idx;
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      cnt_d    = cnt_q;
      retry_d  = retry_q;
      data_d   = data_q;
      pkt_d    = pkt_q;
      done_d   = '0;
      fail_d   = '0;
      att_fail = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               data_d   = win_dat;
               pkt_d    = {4'hF, win_dat ^ 32'hAAAA_AAAA, ~win_dat, win_dat};
               grant_d  = win_idx;
               rr_ptr_d = win_idx;
               retry_d  = '0;
               state_d  = S_SEND;
            end
         end
         S_SEND: begin
            cnt_d   = '0;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               cnt_d   = '0;
               state_d = S_WAIT_ACK;
            end else if (cnt_q >= TO_LAST) begin
               att_fail = 1'b1;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_WAIT_ACK: begin
            // An acknowledge in the timeout cycle still counts: it is checked first.
            if (ack_valid && ack_ok) begin
               done_d  = ONE_HOT0 << grant_q;
               state_d = S_IDLE;
            end else if (ack_valid || cnt_q >= TO_LAST) begin
               att_fail = 1'b1;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (att_fail) begin
         if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 3'd1;
            state_d = S_SEND;
         end else begin
            fail_d  = ONE_HOT0 << grant_q;
            state_d = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= IDW'(NUM_REQ - 1);
         grant_q  <= '0;
         cnt_q    <= '0;
         retry_q  <= '0;
         data_q   <= '0;
         pkt_q    <= '0;
         done_q   <= '0;
         fail_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         cnt_q    <= cnt_d;
         retry_q  <= retry_d;
         data_q   <= data_d;
         pkt_q    <= pkt_d;
         done_q   <= done_d;
         fail_q   <= fail_d;
      end
   end

   assign done       = done_q;
   assign fail       = fail_q;
   assign grant_id   = grant_q;
   assign sched_busy = (state_q != S_IDLE);
   assign tx_start   = (state_q == S_SEND);
   assign tx_data    = data_q;
   assign tx_packet  = pkt_q;
   assign retry_cnt  = retry_q;

endmodule
